// File: rtl/ascon_word_packer_if.sv
// Word-stream and FIFO-push signals of the Ascon word packer.
// The master modport is the environment side; the slave modport is the packer.
interface ascon_word_packer_if #(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 64
);
    logic [WORD_W-1:0]  word_i;
    logic               word_valid_i;
    logic               word_ready_o;
    logic               fifo_full_i;
    logic               push_o;
    logic [BLOCK_W-1:0] block_o;

    modport master (
        output word_i, word_valid_i, fifo_full_i,
        input  word_ready_o, push_o, block_o
    );

    modport slave (
        input  word_i, word_valid_i, fifo_full_i,
        output word_ready_o, push_o, block_o
    );
endinterface

// File: rtl/ascon_word_packer.sv
// Packs a byte-sized message arriving as 32-bit words into zero-filled,
// big-endian 64-bit blocks and pushes one block per FIFO write.
module ascon_word_packer #(
    parameter int WORD_W   = 32,
    parameter int BLOCK_W  = 64,
    parameter int DATA_AW  = 7,
    parameter int BLOCK_AW = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                start_i,
    input  logic [DATA_AW-1:0]  size_i,
    ascon_word_packer_if.slave  bus,
    output logic [BLOCK_AW-1:0] blk_cnt_o,
    output logic                busy_o,
    output logic                done_o
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_PUSH,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [DATA_AW-1:0]  r_bytes_left;
    logic [BLOCK_AW-1:0] r_blk_cnt;
    logic [BLOCK_W-1:0]  r_block;

    logic                w_accept;
    logic                w_full_word;
    logic [DATA_AW-1:0]  w_take;
    logic [DATA_AW-1:0]  w_left_next;
    logic [WORD_W-1:0]   w_mask;
    logic [WORD_W-1:0]   w_word;

    assign bus.word_ready_o = (r_state == S_LOW) || (r_state == S_HIGH);
    assign bus.push_o       = (r_state == S_PUSH) && !bus.fifo_full_i;
    assign bus.block_o      = r_block;
    assign blk_cnt_o        = r_blk_cnt;
    assign busy_o           = (r_state == S_LOW) || (r_state == S_HIGH) || (r_state == S_PUSH);
    assign done_o           = (r_state == S_DONE);

    assign w_accept    = bus.word_valid_i && bus.word_ready_o;
    assign w_full_word = (r_bytes_left >= DATA_AW'(4));
    assign w_take      = w_full_word ? DATA_AW'(4) : r_bytes_left;
    assign w_left_next = r_bytes_left - w_take;

    // Tail word keeps only its leading message bytes; the rest read as zero.
    always_comb begin
        w_mask = '1;
        if (!w_full_word) begin
            case (r_bytes_left[1:0])
                2'd1:    w_mask = 32'hFF00_0000;
                2'd2:    w_mask = 32'hFFFF_0000;
                2'd3:    w_mask = 32'hFFFF_FF00;
                default: w_mask = '0;
            endcase
        end
    end

    assign w_word = bus.word_i & w_mask;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            r_state      <= S_IDLE;
            r_bytes_left <= '0;
            r_blk_cnt    <= '0;
            r_block      <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        r_bytes_left <= size_i;
                        r_blk_cnt    <= '0;
                        r_block      <= '0;
                        r_state      <= (size_i == '0) ? S_DONE : S_LOW;
                    end
                end
                S_LOW: begin
                    if (w_accept) begin
                        r_block[BLOCK_W-1:WORD_W] <= w_word;
                        r_bytes_left              <= w_left_next;
                        r_state                   <= (w_left_next == '0) ? S_PUSH : S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (w_accept) begin
                        r_block[WORD_W-1:0] <= w_word;
                        r_bytes_left        <= w_left_next;
                        r_state             <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (!bus.fifo_full_i) begin
                        r_blk_cnt <= r_blk_cnt + 1'b1;
                        r_block   <= '0;
                        r_state   <= (r_bytes_left == '0) ? S_DONE : S_LOW;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ascon_word_packer.sv
// Directed self-checking bench for ascon_word_packer.
module tb_ascon_word_packer;
    logic       clk = 1'b0;
    logic       rst;
    logic       clear_i;
    logic       start_i;
    logic [6:0] size_i;
    logic [3:0] blk_cnt_o;
    logic       busy_o;
    logic       done_o;

    int n_checks = 0;
    int n_fail   = 0;

    ascon_word_packer_if #(.WORD_W(32), .BLOCK_W(64)) bus ();

    ascon_word_packer #(
        .WORD_W(32), .BLOCK_W(64), .DATA_AW(7), .BLOCK_AW(4)
    ) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i), .start_i(start_i),
        .size_i(size_i), .bus(bus), .blk_cnt_o(blk_cnt_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Observation on the falling edge, half a cycle away from input changes.
    logic [63:0] pushes[$];
    int          n_acc = 0;
    int          n_viol = 0;
    logic        prev_push = 1'b0;

    always @(negedge clk) begin
        if (bus.push_o) pushes.push_back(bus.block_o);
        if (bus.word_valid_i && bus.word_ready_o) n_acc++;
        if (bus.push_o && bus.fifo_full_i) n_viol++;
        if (bus.push_o && prev_push) n_viol++;
        prev_push = bus.push_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_msg(input logic [6:0] sz);
        start_i = 1'b1;
        size_i  = sz;
        tick();
        start_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, output bit ok);
        ok = 1'b0;
        bus.word_i       = w;
        bus.word_valid_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.word_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        bus.word_valid_i = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done_o) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus.push_o, bus.word_ready_o, busy_o, done_o} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b required 0000", {bus.push_o, bus.word_ready_o, busy_o, done_o}); end
        n_checks++; if (blk_cnt_o !== 4'd0) begin
            n_fail++; $display("FAIL reset_blk_cnt: got %0d required 0", blk_cnt_o); end
        n_checks++; if (bus.block_o !== 64'h0) begin
            n_fail++; $display("FAIL reset_block: got %h required 0", bus.block_o); end
        tick();
    endtask

    task automatic test_full_blocks();
        bit ok;
        bit all_ok = 1'b1;
        int p0 = pushes.size();
        int a0 = n_acc;
        start_msg(7'd16);
        send_word(32'h00010203, ok); all_ok &= ok;
        send_word(32'h04050607, ok); all_ok &= ok;
        send_word(32'h08090a0b, ok); all_ok &= ok;
        send_word(32'h0c0d0e0f, ok); all_ok &= ok;
        wait_done(ok); all_ok &= ok;
        n_checks++; if (!all_ok) begin
            n_fail++; $display("FAIL full_timeout: handshake or done not seen, required within budget"); end
        n_checks++; if (pushes.size() - p0 != 2) begin
            n_fail++; $display("FAIL full_npush: got %0d required 2", pushes.size() - p0); end
        else begin
            n_checks++; if (pushes[p0] !== 64'h0001020304050607) begin
                n_fail++; $display("FAIL full_blk0: got %h required 0001020304050607", pushes[p0]); end
            n_checks++; if (pushes[p0+1] !== 64'h08090a0b0c0d0e0f) begin
                n_fail++; $display("FAIL full_blk1: got %h required 08090a0b0c0d0e0f", pushes[p0+1]); end
        end
        n_checks++; if (blk_cnt_o !== 4'd2 || done_o !== 1'b1) begin
            n_fail++; $display("FAIL full_cnt_done: got cnt=%0d done=%b required cnt=2 done=1", blk_cnt_o, done_o); end
        n_checks++; if (n_acc - a0 != 4) begin
            n_fail++; $display("FAIL full_words: got %0d required 4", n_acc - a0); end
    endtask

    task automatic test_partial();
        bit ok;
        bit all_ok = 1'b1;
        int p0 = pushes.size();
        start_msg(7'd5);
        send_word(32'h11223344, ok); all_ok &= ok;
        send_word(32'h55667788, ok); all_ok &= ok;
        wait_done(ok); all_ok &= ok;
        n_checks++; if (!all_ok) begin
            n_fail++; $display("FAIL partial_timeout: handshake or done not seen, required within budget"); end
        n_checks++; if (pushes.size() - p0 != 1) begin
            n_fail++; $display("FAIL partial_npush: got %0d required 1", pushes.size() - p0); end
        else begin
            n_checks++; if (pushes[p0] !== 64'h1122334455000000) begin
                n_fail++; $display("FAIL partial_blk: got %h required 1122334455000000", pushes[p0]); end
        end
        n_checks++; if (blk_cnt_o !== 4'd1 || done_o !== 1'b1) begin
            n_fail++; $display("FAIL partial_cnt_done: got cnt=%0d done=%b required cnt=1 done=1", blk_cnt_o, done_o); end
    endtask

    task automatic test_low_end();
        bit ok;
        bit all_ok = 1'b1;
        int p0 = pushes.size();
        int a0 = n_acc;
        start_msg(7'd12);
        send_word(32'h01020304, ok); all_ok &= ok;
        send_word(32'h05060708, ok); all_ok &= ok;
        send_word(32'h090a0b0c, ok); all_ok &= ok;
        bus.word_i       = 32'hdeadbeef;
        bus.word_valid_i = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.word_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL lowend_ready: got %b required 0", bus.word_ready_o); end
        wait_done(ok); all_ok &= ok;
        repeat (3) tick();
        bus.word_valid_i = 1'b0;
        n_checks++; if (!all_ok) begin
            n_fail++; $display("FAIL lowend_timeout: handshake or done not seen, required within budget"); end
        n_checks++; if (n_acc - a0 != 3) begin
            n_fail++; $display("FAIL lowend_words: got %0d required 3", n_acc - a0); end
        n_checks++; if (pushes.size() - p0 != 2) begin
            n_fail++; $display("FAIL lowend_npush: got %0d required 2", pushes.size() - p0); end
        else begin
            n_checks++; if (pushes[p0] !== 64'h0102030405060708) begin
                n_fail++; $display("FAIL lowend_blk0: got %h required 0102030405060708", pushes[p0]); end
            n_checks++; if (pushes[p0+1] !== 64'h090a0b0c00000000) begin
                n_fail++; $display("FAIL lowend_blk1: got %h required 090a0b0c00000000", pushes[p0+1]); end
        end
    endtask

    task automatic test_zero_size();
        int p0 = pushes.size();
        int a0 = n_acc;
        bus.word_i       = 32'hcafef00d;
        bus.word_valid_i = 1'b1;
        start_msg(7'd0);
        @(negedge clk);
        n_checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL zero_done: got done=%b busy=%b required done=1 busy=0", done_o, busy_o); end
        repeat (5) tick();
        bus.word_valid_i = 1'b0;
        n_checks++; if (n_acc - a0 != 0 || pushes.size() - p0 != 0) begin
            n_fail++; $display("FAIL zero_activity: got acc=%0d push=%0d required 0 0", n_acc - a0, pushes.size() - p0); end
        n_checks++; if (blk_cnt_o !== 4'd0) begin
            n_fail++; $display("FAIL zero_cnt: got %0d required 0", blk_cnt_o); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit all_ok = 1'b1;
        int p0 = pushes.size();
        int a0 = n_acc;
        bus.fifo_full_i = 1'b1;
        start_msg(7'd8);
        send_word(32'ha1b2c3d4, ok); all_ok &= ok;
        send_word(32'he5f60718, ok); all_ok &= ok;
        bus.word_i       = 32'h99999999;
        bus.word_valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (bus.push_o !== 1'b0 || bus.word_ready_o !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold_c%0d: got push=%b ready=%b required 0 0", c, bus.push_o, bus.word_ready_o); end
            n_checks++; if (bus.block_o !== 64'ha1b2c3d4e5f60718) begin
                n_fail++; $display("FAIL bp_block_c%0d: got %h required a1b2c3d4e5f60718", c, bus.block_o); end
            tick();
        end
        bus.fifo_full_i = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.push_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got push=%b required 1", bus.push_o); end
        wait_done(ok); all_ok &= ok;
        bus.word_valid_i = 1'b0;
        n_checks++; if (!all_ok) begin
            n_fail++; $display("FAIL bp_timeout: handshake or done not seen, required within budget"); end
        n_checks++; if (n_acc - a0 != 2 || pushes.size() - p0 != 1) begin
            n_fail++; $display("FAIL bp_counts: got acc=%0d push=%0d required 2 1", n_acc - a0, pushes.size() - p0); end
        else begin
            n_checks++; if (pushes[p0] !== 64'ha1b2c3d4e5f60718) begin
                n_fail++; $display("FAIL bp_pushed: got %h required a1b2c3d4e5f60718", pushes[p0]); end
        end
    endtask

    task automatic test_clear_and_rst();
        bit ok;
        bit all_ok = 1'b1;
        int p0 = pushes.size();
        start_msg(7'd8);
        send_word(32'hffffffff, ok); all_ok &= ok;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        @(negedge clk);
        n_checks++; if ({busy_o, done_o, bus.word_ready_o, bus.push_o} !== 4'b0000) begin
            n_fail++; $display("FAIL clear_idle: got %b required 0000", {busy_o, done_o, bus.word_ready_o, bus.push_o}); end
        repeat (3) tick();
        n_checks++; if (pushes.size() != p0) begin
            n_fail++; $display("FAIL clear_nopush: got %0d pushes required 0", pushes.size() - p0); end
        start_msg(7'd8);
        send_word(32'h01234567, ok); all_ok &= ok;
        send_word(32'h89abcdef, ok); all_ok &= ok;
        wait_done(ok); all_ok &= ok;
        n_checks++; if (pushes.size() - p0 != 1) begin
            n_fail++; $display("FAIL clear_restart_n: got %0d required 1", pushes.size() - p0); end
        else begin
            n_checks++; if (pushes[p0] !== 64'h0123456789abcdef) begin
                n_fail++; $display("FAIL clear_restart_blk: got %h required 0123456789abcdef", pushes[p0]); end
        end
        start_msg(7'd8);
        send_word(32'heeeeeeee, ok); all_ok &= ok;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({busy_o, done_o, bus.word_ready_o} !== 3'b000 || blk_cnt_o !== 4'd0 || bus.block_o !== 64'h0) begin
            n_fail++; $display("FAIL rst_mid: got flags=%b cnt=%0d block=%h required 000 0 0", {busy_o, done_o, bus.word_ready_o}, blk_cnt_o, bus.block_o); end
        repeat (3) tick();
        n_checks++; if (pushes.size() - p0 != 1) begin
            n_fail++; $display("FAIL rst_nopush: got %0d pushes required 1", pushes.size() - p0); end
        n_checks++; if (!all_ok) begin
            n_fail++; $display("FAIL clear_timeout: handshake or done not seen, required within budget"); end
    endtask

    // Byte n of the message is n, so block j holds bytes 8j..8j+7.
    task automatic test_max_wrap();
        bit ok;
        bit all_ok = 1'b1;
        int p0 = pushes.size();
        int a0 = n_acc;
        logic [7:0] b;
        start_msg(7'd127);
        for (int k = 0; k < 32; k++) begin
            b = 8'(4 * k);
            send_word({b, b + 8'd1, b + 8'd2, b + 8'd3}, ok);
            all_ok &= ok;
        end
        wait_done(ok); all_ok &= ok;
        n_checks++; if (!all_ok) begin
            n_fail++; $display("FAIL wrap_timeout: handshake or done not seen, required within budget"); end
        n_checks++; if (n_acc - a0 != 32 || pushes.size() - p0 != 16) begin
            n_fail++; $display("FAIL wrap_counts: got acc=%0d push=%0d required 32 16", n_acc - a0, pushes.size() - p0); end
        else begin
            n_checks++; if (pushes[p0+1] !== 64'h08090a0b0c0d0e0f) begin
                n_fail++; $display("FAIL wrap_blk1: got %h required 08090a0b0c0d0e0f", pushes[p0+1]); end
            n_checks++; if (pushes[p0+15] !== 64'h78797a7b7c7d7e00) begin
                n_fail++; $display("FAIL wrap_last: got %h required 78797a7b7c7d7e00", pushes[p0+15]); end
        end
        n_checks++; if (blk_cnt_o !== 4'd0 || done_o !== 1'b1) begin
            n_fail++; $display("FAIL wrap_cnt: got cnt=%0d done=%b required cnt=0 done=1", blk_cnt_o, done_o); end
    endtask

    initial begin
        rst              = 1'b1;
        clear_i          = 1'b0;
        start_i          = 1'b0;
        size_i           = '0;
        bus.word_i       = '0;
        bus.word_valid_i = 1'b0;
        bus.fifo_full_i  = 1'b0;
        tick();
        test_reset();
        test_full_blocks();
        test_partial();
        test_low_end();
        test_zero_size();
        test_backpressure();
        test_clear_and_rst();
        test_max_wrap();
        n_checks++; if (n_viol != 0) begin
            n_fail++; $display("FAIL push_rules: got %0d violations required 0", n_viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
